// File: rtl/regfile_write_bank.sv
// Write side of the general-purpose register file: one-hot write decode
// feeding a bank of 32 registers, each exposed on its own output port.
module regfile_write_bank #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WE,
  input  logic [4:0]       Awr,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7,
  output logic [WIDTH-1:0] Q8,
  output logic [WIDTH-1:0] Q9,
  output logic [WIDTH-1:0] Q10,
  output logic [WIDTH-1:0] Q11,
  output logic [WIDTH-1:0] Q12,
  output logic [WIDTH-1:0] Q13,
  output logic [WIDTH-1:0] Q14,
  output logic [WIDTH-1:0] Q15,
  output logic [WIDTH-1:0] Q16,
  output logic [WIDTH-1:0] Q17,
  output logic [WIDTH-1:0] Q18,
  output logic [WIDTH-1:0] Q19,
  output logic [WIDTH-1:0] Q20,
  output logic [WIDTH-1:0] Q21,
  output logic [WIDTH-1:0] Q22,
  output logic [WIDTH-1:0] Q23,
  output logic [WIDTH-1:0] Q24,
  output logic [WIDTH-1:0] Q25,
  output logic [WIDTH-1:0] Q26,
  output logic [WIDTH-1:0] Q27,
  output logic [WIDTH-1:0] Q28,
  output logic [WIDTH-1:0] Q29,
  output logic [WIDTH-1:0] Q30,
  output logic [WIDTH-1:0] Q31,
  output logic [31:0]      WrDec
);

  logic [31:0]      wr_dec;
  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_dec = '0;
    if (WE) wr_dec[Awr] = 1'b1;
    if (ZERO_REG) wr_dec[0] = 1'b0;
  end

  assign WrDec = wr_dec;

  // NOTE: blocking assignments belong in always_comb; the flop block below
  // uses non-blocking so all registers update from pre-edge values.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 32; i++) begin
      if (wr_dec[i]) regs_d[i] = Din;
    end
  end

  // NOTE: the bank is a flop array, not a RAM macro, so it can and must
  // take the asynchronous clear that the architectural reset demands.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Register 0 reads constant zero when hardwired, even before the first reset.
  assign Q0  = ZERO_REG ? '0 : regs_q[0];
  assign Q1  = regs_q[1];
  assign Q2  = regs_q[2];
  assign Q3  = regs_q[3];
  assign Q4  = regs_q[4];
  assign Q5  = regs_q[5];
  assign Q6  = regs_q[6];
  assign Q7  = regs_q[7];
  assign Q8  = regs_q[8];
  assign Q9  = regs_q[9];
  assign Q10 = regs_q[10];
  assign Q11 = regs_q[11];
  assign Q12 = regs_q[12];
  assign Q13 = regs_q[13];
  assign Q14 = regs_q[14];
  assign Q15 = regs_q[15];
  assign Q16 = regs_q[16];
  assign Q17 = regs_q[17];
  assign Q18 = regs_q[18];
  assign Q19 = regs_q[19];
  assign Q20 = regs_q[20];
  assign Q21 = regs_q[21];
  assign Q22 = regs_q[22];
  assign Q23 = regs_q[23];
  assign Q24 = regs_q[24];
  assign Q25 = regs_q[25];
  assign Q26 = regs_q[26];
  assign Q27 = regs_q[27];
  assign Q28 = regs_q[28];
  assign Q29 = regs_q[29];
  assign Q30 = regs_q[30];
  assign Q31 = regs_q[31];

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank: a hardwired-zero instance plus a
// ZERO_REG=0 instance sharing the same stimulus.
module tb_regfile_write_bank;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        WE;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic [31:0] q  [32];
  logic [31:0] q1 [32];
  logic [31:0] wr_dec, wr_dec1;
  logic [31:0] exp_q [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 Clk = ~Clk;

  regfile_write_bank #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .WE(WE), .Awr(Awr), .Din(Din),
    .Q0(q[0]),   .Q1(q[1]),   .Q2(q[2]),   .Q3(q[3]),
    .Q4(q[4]),   .Q5(q[5]),   .Q6(q[6]),   .Q7(q[7]),
    .Q8(q[8]),   .Q9(q[9]),   .Q10(q[10]), .Q11(q[11]),
    .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
    .Q16(q[16]), .Q17(q[17]), .Q18(q[18]), .Q19(q[19]),
    .Q20(q[20]), .Q21(q[21]), .Q22(q[22]), .Q23(q[23]),
    .Q24(q[24]), .Q25(q[25]), .Q26(q[26]), .Q27(q[27]),
    .Q28(q[28]), .Q29(q[29]), .Q30(q[30]), .Q31(q[31]),
    .WrDec(wr_dec)
  );

  regfile_write_bank #(.WIDTH(32), .ZERO_REG(1'b0)) dut_nz (
    .Clk(Clk), .Reset(Reset), .WE(WE), .Awr(Awr), .Din(Din),
    .Q0(q1[0]),   .Q1(q1[1]),   .Q2(q1[2]),   .Q3(q1[3]),
    .Q4(q1[4]),   .Q5(q1[5]),   .Q6(q1[6]),   .Q7(q1[7]),
    .Q8(q1[8]),   .Q9(q1[9]),   .Q10(q1[10]), .Q11(q1[11]),
    .Q12(q1[12]), .Q13(q1[13]), .Q14(q1[14]), .Q15(q1[15]),
    .Q16(q1[16]), .Q17(q1[17]), .Q18(q1[18]), .Q19(q1[19]),
    .Q20(q1[20]), .Q21(q1[21]), .Q22(q1[22]), .Q23(q1[23]),
    .Q24(q1[24]), .Q25(q1[25]), .Q26(q1[26]), .Q27(q1[27]),
    .Q28(q1[28]), .Q29(q1[29]), .Q30(q1[30]), .Q31(q1[31]),
    .WrDec(wr_dec1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s Q%0d", tag, i), q[i], exp_q[i]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_q[i] = '0;
  endtask

  // Drive one cycle away from the edge, check the decode, clock, then update the model.
  task automatic write_cycle(input logic we, input logic [4:0] a, input logic [31:0] d,
                             input logic [31:0] exp_dec, input string tag);
    @(negedge Clk);
    WE = we; Awr = a; Din = d;
    #1 check({tag, " WrDec"}, wr_dec, exp_dec);
    @(posedge Clk);
    #1;
    if (we && a != 5'd0) exp_q[a] = d;
  endtask

  initial begin
    Reset = 1'b1; WE = 1'b0; Awr = '0; Din = '0;
    clear_model();
    #2 check_all("reset");
    check("reset WrDec", wr_dec, 32'h0);

    // Load R5, then assert Reset mid-cycle: Q5 must clear before the next edge.
    @(negedge Clk) Reset = 1'b0;
    write_cycle(1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_0020, "r5");
    check("r5 load", q[5], 32'hDEADBEEF);
    Reset = 1'b1;
    #1 check("async clear Q5", q[5], 32'h0);
    clear_model();
    check_all("async clear");
    @(negedge Clk) Reset = 1'b0;

    // Hardwired zero discards a write of all ones.
    write_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 32'h0, "zero");
    check("zero Q0", q[0], 32'h0);

    for (int n = 1; n < 32; n++)
      write_cycle(1'b1, n[4:0], 32'h1000_0000 + n, 32'h1 << n, $sformatf("sweep%0d", n));
    check_all("sweep");

    for (int k = 0; k < 3; k++)
      write_cycle(1'b0, 5'd7, 32'h12345678, 32'h0, "we_off");
    check("we_off Q7", q[7], 32'h10000007);
    check_all("we_off");

    write_cycle(1'b1, 5'd31, 32'hAAAA0000, 32'h8000_0000, "b2b1");
    check("b2b edge1 Q31", q[31], 32'hAAAA0000);
    write_cycle(1'b1, 5'd31, 32'h5555FFFF, 32'h8000_0000, "b2b2");
    check("b2b edge2 Q31", q[31], 32'h5555FFFF);
    check_all("b2b");

    // Reset spans a write edge: decode stays live but the write is lost.
    @(negedge Clk);
    WE = 1'b1; Awr = 5'd12; Din = 32'hCAFEF00D; Reset = 1'b1;
    #1 check("rst_wr WrDec", wr_dec, 32'h0000_1000);
    @(posedge Clk);
    #1 check("rst_wr during Q12", q[12], 32'h0);
    @(negedge Clk);
    Reset = 1'b0; WE = 1'b0;
    #1 clear_model();
    check("rst_wr after Q12", q[12], 32'h0);
    check_all("rst_wr");

    // ZERO_REG=0 instance treats register 0 as ordinary.
    @(negedge Clk);
    WE = 1'b1; Awr = 5'd0; Din = 32'h00000042;
    #1 check("nz WrDec", wr_dec1, 32'h0000_0001);
    check("z WrDec", wr_dec, 32'h0);
    @(posedge Clk);
    #1 check("nz Q0", q1[0], 32'h00000042);
    check("z Q0", q[0], 32'h0);
    @(negedge Clk) WE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the general-purpose register file; the counterpart of the 32:1 read multiplexer.
- A 5-bit write address is decoded one-hot to 32 write enables. These load a bank of 32 registers.
- The bank's contents drive Q0..Q31, which feed the read-port mux inputs In0..In31 directly.
- Sits in the write-back stage of the single-cycle/multicycle MIPS datapath.

Parameters:
- WIDTH, 32, data width of each register and of Din/Q0..Q31.
- ZERO_REG, 1, when 1, register 0 is hardwired to zero and writes to it are discarded; when 0, register 0 is an ordinary register.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears every register.
- WE  input  1  write enable (RegWrite from control).
- Awr  input  5  write register address (rd/rt after RegDst select).
- Din  input  WIDTH  write-back data.
- Q0..Q31  output  WIDTH each  current contents of registers 0..31, one port per register.
- WrDec  output  32  one-hot decoded write enable actually applied this cycle. Bit n = WE & (Awr==n), with bit 0 forced 0 when ZERO_REG=1. Combinational.

Behaviour:
- Reset
  - Reset=1 clears all 32 registers to 0 immediately, without waiting for a clock edge.
  - Q0..Q31 read 0 for as long as Reset is held.
  - WrDec stays combinational and is not gated by Reset.
  - Reset asserted in the same cycle as a write: reset wins, and no register holds Din after Reset deasserts.
- Decode
  - WrDec[n] = WE && Awr==n. At most one bit is set.
  - WE=0 gives WrDec all zeros.
- Write
  - On a Clk rising edge with Reset=0, every register n with WrDec[n]=1 loads Din. All other registers hold their value.
  - Latency: the new value appears on Qn after that edge and is visible to the read mux in the next cycle.
  - There is no internal write-to-read bypass. Same-cycle forwarding is the hazard unit's job.
- Zero register
  - ZERO_REG=1: Q0 is constant 0 regardless of WE, Awr or Din, and WrDec[0] is always 0.
  - ZERO_REG=0: register 0 behaves like registers 1..31.
- Back-to-back writes
  - Consecutive cycles writing the same address: each edge overwrites, so the last write wins.
  - Consecutive cycles writing different addresses are independent.
- Width: Din loads unmodified, with no sign or zero extension inside the block.
- Outputs are glitch-free registered values, apart from Q0 when hardwired and from WrDec.

Test Plan:
- Reset and hardwired zero: assert Reset mid-cycle after loading 32'hDEADBEEF into R5 -> Q5 drops to 0 before the next edge and all Qn read 0. Then release Reset, set WE=1, Awr=0, Din=32'hFFFFFFFF and clock -> Q0 stays 0 and WrDec=32'h0 (ZERO_REG=1).
- Full sweep: for n=1..31 write Din=32'h1000_0000+n with WE=1, Awr=n -> WrDec=1<<n during each cycle. After the sweep, Qn=32'h1000_0000+n for all n and Q0=0.
- Write enable off: WE=0, Awr=7, Din=32'h12345678 over 3 edges -> WrDec=0 and Q7 unchanged from its previous value 32'h10000007.
- Same-address back-to-back: Awr=31 with Din=32'hAAAA0000 then 32'h5555FFFF on consecutive edges -> Q31=32'hAAAA0000 after edge 1 and 32'h5555FFFF after edge 2. No other Qn changes.
- Reset during write: WE=1, Awr=12, Din=32'hCAFEF00D with Reset=1 spanning the edge -> Q12=0 after Reset deasserts.
- ZERO_REG=0 build: WE=1, Awr=0, Din=32'h00000042 and clock -> Q0=32'h00000042 and WrDec=32'h00000001.
